udp_send: RTL and testbench

//  Transmit-side counterpart of the UDP receive path: builds and emits one complete

---
 rtl/udp_send.sv | 194 +++++++++++++++++++
 tb/tb_udp_send.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_send.sv
// udp_send: builds one Ethernet II / IPv4 / UDP frame per start request and
// streams it byte-wise onto an 8-bit GMII-style transmit port.
module udp_send #(
  parameter logic [47:0] SRC_MAC  = 48'h000a3501fec0,
  parameter logic [31:0] SRC_ADDR = 32'hc0a80002,
  parameter logic [15:0] SRC_PORT = 16'd8000,
  parameter logic [47:0] DST_MAC  = 48'hffffffffffff,
  parameter logic [31:0] DST_ADDR = 32'hc0a80003,
  parameter logic [15:0] DST_PORT = 16'd8000,
  parameter logic [7:0]  TTL      = 8'd64,
  parameter int unsigned IFG_CNT  = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] data_len,
  output logic        data_req,
  input  logic [7:0]  data_i,
  output logic        busy,
  output logic        done,
  output logic        e_txen,
  output logic [7:0]  txd
);

  localparam logic [15:0] MAX_LEN  = 16'd1472;
  localparam logic [15:0] IFG_LAST = 16'(IFG_CNT - 1);
  localparam logic [31:0] CRC_POLY = 32'hedb88320;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_MAC, S_HDR, S_DATA, S_PAD, S_FCS, S_IFG
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [15:0] id_q, id_d;
  logic [15:0] csum_q, csum_d;
  logic [31:0] crc_q, crc_d;

  logic [15:0]      ip_total;
  logic [15:0]      udp_len;
  logic [4:0]       pad_cnt;
  logic [31:0]      sum_raw;
  logic [16:0]      sum_fold1;
  logic [15:0]      sum_fold2;
  logic [13:0][7:0] mac_bytes;
  logic [27:0][7:0] hdr_bytes;
  logic [3:0]       mac_idx;
  logic [4:0]       hdr_idx;
  logic [31:0]      fcs;

  // Reflected CRC-32 advanced by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ({1'b0, r[31:1]} ^ CRC_POLY) : {1'b0, r[31:1]};
    end
    return r;
  endfunction

  assign ip_total = len_q + 16'd28;
  assign udp_len  = len_q + 16'd8;
  assign pad_cnt  = (len_q < 16'd18) ? 5'(16'd18 - len_q) : 5'd0;

  assign sum_raw = 32'h0000_4500 + {16'h0, ip_total} + {16'h0, id_q} + 32'h0000_4000
                 + {16'h0, TTL, 8'h11}
                 + {16'h0, SRC_ADDR[31:16]} + {16'h0, SRC_ADDR[15:0]}
                 + {16'h0, DST_ADDR[31:16]} + {16'h0, DST_ADDR[15:0]};
  assign sum_fold1 = {1'b0, sum_raw[15:0]} + {1'b0, sum_raw[31:16]};
  assign sum_fold2 = sum_fold1[15:0] + {15'd0, sum_fold1[16]};

  assign mac_bytes = {DST_MAC, SRC_MAC, 16'h0800};
  assign hdr_bytes = {8'h45, 8'h00, ip_total, id_q, 16'h4000, TTL, 8'h11, csum_q,
                      SRC_ADDR, DST_ADDR, SRC_PORT, DST_PORT, udp_len, 16'h0000};
  assign mac_idx   = 4'd13 - cnt_q[3:0];
  assign hdr_idx   = 5'd27 - cnt_q[4:0];
  assign fcs       = ~crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      id_q    <= '0;
      csum_q  <= '0;
      crc_q   <= 32'hffffffff;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      id_q    <= id_d;
      csum_q  <= csum_d;
      crc_q   <= crc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_PRE;
      end
      S_PRE: if (cnt_q == 16'd7) begin
        state_d = S_MAC;
        cnt_d   = '0;
      end
      S_MAC: if (cnt_q == 16'd13) begin
        state_d = S_HDR;
        cnt_d   = '0;
      end
      S_HDR: if (cnt_q == 16'd27) begin
        cnt_d   = '0;
        state_d = (len_q != 16'd0) ? S_DATA : ((pad_cnt != 5'd0) ? S_PAD : S_FCS);
      end
      S_DATA: if (cnt_q == len_q - 16'd1) begin
        cnt_d   = '0;
        state_d = (pad_cnt != 5'd0) ? S_PAD : S_FCS;
      end
      S_PAD: if (cnt_q == {11'd0, pad_cnt} - 16'd1) begin
        state_d = S_FCS;
        cnt_d   = '0;
      end
      S_FCS: if (cnt_q == 16'd3) begin
        state_d = S_IFG;
        cnt_d   = '0;
      end
      S_IFG: if (cnt_q == IFG_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Checksum is latched during the preamble, long before HDR byte 10 reads it.
  always_comb begin
    len_d  = len_q;
    id_d   = id_q;
    csum_d = csum_q;
    crc_d  = crc_q;
    case (state_q)
      S_IDLE: if (start) len_d = (data_len > MAX_LEN) ? MAX_LEN : data_len;
      S_PRE: begin
        csum_d = ~sum_fold2;
        crc_d  = 32'hffffffff;
      end
      S_MAC, S_HDR, S_DATA, S_PAD: crc_d = crc32_byte(crc_q, txd);
      S_FCS: if (cnt_q == 16'd3) id_d = id_q + 16'd1;
      default: ;
    endcase
  end

  always_comb begin
    txd      = 8'h00;
    e_txen   = 1'b0;
    data_req = 1'b0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_PRE: begin
        e_txen = 1'b1;
        txd    = (cnt_q == 16'd7) ? 8'hd5 : 8'h55;
      end
      S_MAC: begin
        e_txen = 1'b1;
        txd    = mac_bytes[mac_idx];
      end
      S_HDR: begin
        e_txen   = 1'b1;
        txd      = hdr_bytes[hdr_idx];
        data_req = (cnt_q == 16'd27) && (len_q != 16'd0);
      end
      S_DATA: begin
        e_txen   = 1'b1;
        txd      = data_i;
        data_req = (cnt_q < len_q - 16'd1);
      end
      S_PAD: e_txen = 1'b1;
      S_FCS: begin
        e_txen = 1'b1;
        txd    = fcs[{cnt_q[1:0], 3'b000} +: 8];
      end
      S_IFG: done = (cnt_q == IFG_LAST);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_udp_send.sv
// tb_udp_send: random-length frames against a byte-level frame model built from
// the protocol rules (header fields, one's-complement checksum, MSB-first CRC-32).
`timescale 1ns/1ps
module tb_udp_send;

  localparam int          IFG_CNT  = 12;
  localparam int          MAX_LEN  = 1472;
  localparam logic [47:0] SRC_MAC  = 48'h000a3501fec0;
  localparam logic [31:0] SRC_ADDR = 32'hc0a80002;
  localparam logic [15:0] SRC_PORT = 16'd8000;
  localparam logic [47:0] DST_MAC  = 48'hffffffffffff;
  localparam logic [31:0] DST_ADDR = 32'hc0a80003;
  localparam logic [15:0] DST_PORT = 16'd8000;
  localparam logic [7:0]  TTL      = 8'd64;

  typedef byte unsigned bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] data_len = 16'd0;
  logic        data_req;
  logic [7:0]  data_i = 8'h00;
  logic        busy, done, e_txen;
  logic [7:0]  txd;

  udp_send dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_len(data_len),
    .data_req(data_req), .data_i(data_i), .busy(busy), .done(done),
    .e_txen(e_txen), .txd(txd)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_id = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Payload memory: one-cycle read latency after data_req.
  byte unsigned ram_mem[$];
  int rd_ptr = 0;
  int req_cnt = 0;
  always @(posedge clk) begin
    if (data_req === 1'b1) begin
      data_i  <= (rd_ptr < ram_mem.size()) ? ram_mem[rd_ptr] : 8'hee;
      rd_ptr  <= rd_ptr + 1;
      req_cnt <= req_cnt + 1;
    end
  end

  // Wire monitor, sampled on the falling edge.
  bq_t  cap_q;
  int   cyc = 0;
  int   n_starts = 0;
  int   first_on = 0;
  int   last_on = 0;
  int   idle_txd_bad = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (e_txen === 1'b1) begin
      cap_q.push_back(txd);
      last_on <= cyc;
      if (prev_en !== 1'b1) begin
        n_starts <= n_starts + 1;
        first_on <= cyc;
      end
    end else if (txd !== 8'h00) begin
      idle_txd_bad <= idle_txd_bad + 1;
    end
    prev_en <= e_txen;
    cyc     <= cyc + 1;
  end

  function automatic bq_t build_frame(input int dlen, input int id, input int base);
    bq_t         f;
    int          len, pad, s;
    int          w[10];
    logic [31:0] crc;
    logic [7:0]  b, r;
    logic        fb;
    len = (dlen > MAX_LEN) ? MAX_LEN : dlen;
    pad = (len < 18) ? 18 - len : 0;
    for (int i = 0; i < 7; i++) f.push_back(8'h55);
    f.push_back(8'hd5);
    for (int i = 5; i >= 0; i--) f.push_back(8'(DST_MAC >> (8 * i)));
    for (int i = 5; i >= 0; i--) f.push_back(8'(SRC_MAC >> (8 * i)));
    f.push_back(8'h08);
    f.push_back(8'h00);
    w[0] = 'h4500;
    w[1] = len + 28;
    w[2] = id & 'hffff;
    w[3] = 'h4000;
    w[4] = int'(TTL) * 256 + 17;
    w[5] = 0;
    w[6] = int'(SRC_ADDR[31:16]);
    w[7] = int'(SRC_ADDR[15:0]);
    w[8] = int'(DST_ADDR[31:16]);
    w[9] = int'(DST_ADDR[15:0]);
    s = 0;
    for (int i = 0; i < 10; i++) s += w[i];
    while (s > 'hffff) s = (s & 'hffff) + (s >> 16);
    w[5] = (~s) & 'hffff;
    for (int i = 0; i < 10; i++) begin
      f.push_back(8'(w[i] >> 8));
      f.push_back(8'(w[i]));
    end
    f.push_back(8'(SRC_PORT >> 8));
    f.push_back(8'(SRC_PORT));
    f.push_back(8'(DST_PORT >> 8));
    f.push_back(8'(DST_PORT));
    f.push_back(8'((len + 8) >> 8));
    f.push_back(8'(len + 8));
    f.push_back(8'h00);
    f.push_back(8'h00);
    for (int i = 0; i < len; i++) f.push_back(ram_mem[base + i]);
    for (int i = 0; i < pad; i++) f.push_back(8'h00);
    // Textbook MSB-first CRC-32 with bytes fed LSB first (wire order).
    crc = 32'hffffffff;
    for (int k = 8; k < f.size(); k++) begin
      b = f[k];
      for (int j = 0; j < 8; j++) begin
        fb  = crc[31] ^ b[j];
        crc = {crc[30:0], 1'b0};
        if (fb) crc = crc ^ 32'h04c11db7;
      end
    end
    crc = ~crc;
    for (int idx = 3; idx >= 0; idx--) begin
      b = crc[8 * idx +: 8];
      for (int j = 0; j < 8; j++) r[j] = b[7 - j];
      f.push_back(r);
    end
    return f;
  endfunction

  // mode: 0 = start low, 1 = single start pulse mid-payload, 2 = start held high
  task automatic wait_done(input int mode, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (mode == 1) start = (c == 55);
      if (done === 1'b1) seen = 1'b1;
    end
    if (mode != 2) start = 1'b0;
  endtask

  task automatic check_frame(input bq_t exp, input int cap0, input int dlen, input int id);
    int got_n, bad, len, pad;
    len   = (dlen > MAX_LEN) ? MAX_LEN : dlen;
    pad   = (len < 18) ? 18 - len : 0;
    got_n = cap_q.size() - cap0;
    check_val("wire_len", got_n, 8 + 14 + 28 + len + pad + 4);
    bad = 0;
    for (int i = 0; i < exp.size(); i++) begin
      if (cap0 + i >= cap_q.size()) bad++;
      else if (cap_q[cap0 + i] != exp[i]) bad++;
    end
    check_val("frame_bytes_bad", bad, 0);
    if (got_n >= 50) begin
      check_val("ip_total", {cap_q[cap0 + 24], cap_q[cap0 + 25]}, len + 28);
      check_val("ip_id", {cap_q[cap0 + 26], cap_q[cap0 + 27]}, id & 'hffff);
      check_val("ip_csum", {cap_q[cap0 + 32], cap_q[cap0 + 33]}, {exp[32], exp[33]});
      check_val("udp_len", {cap_q[cap0 + 46], cap_q[cap0 + 47]}, len + 8);
    end
  endtask

  task automatic run_frame(input int dlen, input bit rand_pl, input int mode);
    int  len, base, cap0, req0, st0;
    bq_t exp;
    bit  seen;
    len  = (dlen > MAX_LEN) ? MAX_LEN : dlen;
    base = ram_mem.size();
    for (int i = 0; i < len; i++)
      ram_mem.push_back(rand_pl ? 8'($urandom_range(0, 255)) : 8'(i + 1));
    exp  = build_frame(dlen, exp_id, base);
    cap0 = cap_q.size();
    req0 = req_cnt;
    st0  = n_starts;
    @(negedge clk);
    start    = 1'b1;
    data_len = 16'(dlen);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("first_busy", busy, 1);
    check_val("first_txen", e_txen, 1);
    check_val("first_txd", txd, 8'h55);
    wait_done(mode, seen);
    check_val("done_seen", seen, 1);
    check_val("busy_on_done", busy, 1);
    @(posedge clk);
    #1;
    check_val("busy_after_done", busy, 0);
    check_val("done_width", done, 0);
    check_frame(exp, cap0, dlen, exp_id);
    check_val("data_req_cycles", req_cnt - req0, len);
    check_val("txen_bursts", n_starts - st0, 1);
    check_val("idle_txd_zero", idle_txd_bad, 0);
    $display("frame data_len=%0d len=%0d id=%0d wire=%0d req=%0d",
             dlen, len, exp_id, cap_q.size() - cap0, req_cnt - req0);
    exp_id = (exp_id + 1) & 'hffff;
  endtask

  initial begin
    int  base, cap0, st0, req0, last1;
    bit  seen;
    bq_t e1, e2;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_txen", e_txen, 0);
    check_val("rst_txd", txd, 0);
    check_val("rst_data_req", data_req, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(4, 1'b0, 0);
    run_frame(0, 1'b1, 0);
    run_frame(18, 1'b1, 0);
    run_frame(2000, 1'b1, 0);
    for (int i = 0; i < 4; i++) run_frame($urandom_range(1, 80), 1'b1, 0);

    // start pulsed mid-payload must not queue a second frame
    st0 = n_starts;
    run_frame(40, 1'b1, 1);
    repeat (20) @(posedge clk);
    #1;
    check_val("poke_no_restart", busy, 0);
    check_val("poke_bursts", n_starts - st0, 1);

    // back-to-back frames with start held high
    base = ram_mem.size();
    for (int i = 0; i < 6 + 25; i++) ram_mem.push_back(8'($urandom_range(0, 255)));
    e1   = build_frame(6, exp_id, base);
    e2   = build_frame(25, (exp_id + 1) & 'hffff, base + 6);
    cap0 = cap_q.size();
    @(negedge clk);
    start    = 1'b1;
    data_len = 16'd6;
    @(posedge clk);
    #1;
    data_len = 16'd25;
    wait_done(2, seen);
    check_val("b2b_done1", seen, 1);
    check_frame(e1, cap0, 6, exp_id);
    $display("frame b2b#1 len=6 id=%0d wire=%0d", exp_id, cap_q.size() - cap0);
    exp_id = (exp_id + 1) & 'hffff;
    last1  = last_on;
    cap0   = cap_q.size();
    seen   = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    check_val("b2b_accept", seen, 1);
    wait_done(0, seen);
    check_val("b2b_done2", seen, 1);
    check_frame(e2, cap0, 25, exp_id);
    check_val("ifg_gap", first_on - last1 - 1, IFG_CNT + 1);
    $display("frame b2b#2 len=25 id=%0d wire=%0d gap=%0d", exp_id, cap_q.size() - cap0,
             first_on - last1 - 1);
    exp_id = (exp_id + 1) & 'hffff;
    repeat (2) @(posedge clk);

    // asynchronous reset while the IP header is on the wire
    req0 = req_cnt;
    @(negedge clk);
    start    = 1'b1;
    data_len = 16'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (25) @(posedge clk);
    #3;
    check_val("pre_arst_txen", e_txen, 1);
    rst_n = 1'b0;
    #1;
    check_val("arst_txen", e_txen, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_txd", txd, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_val("arst_no_req", req_cnt - req0, 0);
    $display("abort data_len=10 by reset in header");
    exp_id = 0;
    run_frame(12, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
